// File: rtl/mux_arb_n.sv
// N:1 registered multiplexer with valid/ready handshake and built-in fixed-priority or
// round-robin arbitration. Define MUX_ARB_LOCK_EN to hold the grant for a whole packet.
module mux_arb_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 10,
  parameter int unsigned RR    = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N*WIDTH-1:0]                  in_data,
  input  logic [N-1:0]                        in_valid,
  input  logic [N-1:0]                        in_last,
  output logic [N-1:0]                        in_ready,
  output logic [WIDTH-1:0]                    out_data,
  output logic                                out_valid,
  output logic                                out_last,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_sel,
  input  logic                                out_ready
);

  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [SELW-1:0]  out_sel_q;
  logic [SELW-1:0]  ptr_q;
`ifdef MUX_ARB_LOCK_EN
  logic             lock_q;
  logic [SELW-1:0]  lock_sel_q;
`endif

  logic             load;
  logic             gnt_any;
  logic [SELW-1:0]  gnt_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic [SELW-1:0]  ptr_next;
  int unsigned      base;
  int unsigned      idx;

  assign load = !out_valid_q || out_ready;

  // Scan from the pointer (0 for fixed priority) upwards with wrap; first valid wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    base    = (RR != 0) ? int'(ptr_q) : 0;
    idx     = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SELW-1:0];
      end
    end
`ifdef MUX_ARB_LOCK_EN
    // A locked channel owns the output even while its valid is low.
    if (lock_q) begin
      gnt_idx = lock_sel_q;
      gnt_any = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (SELW'(i) == lock_sel_q) gnt_any = in_valid[i];
      end
    end
`endif
  end

  always_comb begin
    grant    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      grant[i] = gnt_any && (gnt_idx == SELW'(i));
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_last = in_last[i];
      end
    end
    ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign in_ready = (rst_n && load) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_sel_q  <= '0;
`endif
    end else if (load) begin
      out_valid_q <= gnt_any;
      if (gnt_any) begin
        out_data_q <= sel_data;
        out_last_q <= sel_last;
        out_sel_q  <= gnt_idx;
`ifdef MUX_ARB_LOCK_EN
        lock_q     <= !sel_last;
        lock_sel_q <= gnt_idx;
        if (sel_last) ptr_q <= ptr_next;
`else
        ptr_q      <= ptr_next;
`endif
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: fixed-priority and round-robin 10-channel instances sharing
// stimulus, plus an 8-bit single-channel instance.
module tb_mux_arb_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [159:0] in_data;
  logic [9:0]   in_valid;
  logic [9:0]   in_last;
  logic         out_ready;

  logic [9:0]   fp_in_ready, rr_in_ready;
  logic [15:0]  fp_out_data, rr_out_data;
  logic         fp_out_valid, rr_out_valid, fp_out_last, rr_out_last;
  logic [3:0]   fp_out_sel, rr_out_sel;

  logic [7:0]   n1_in_data, n1_out_data;
  logic [0:0]   n1_in_valid, n1_in_last, n1_in_ready, n1_out_sel;
  logic         n1_out_valid, n1_out_last, n1_out_ready;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(16), .N(10), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_valid(fp_out_valid),
    .out_last(fp_out_last), .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(16), .N(10), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_valid(rr_out_valid),
    .out_last(rr_out_last), .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(8), .N(1), .RR(0)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_data(n1_in_data), .in_valid(n1_in_valid),
    .in_last(n1_in_last), .in_ready(n1_in_ready), .out_data(n1_out_data),
    .out_valid(n1_out_valid), .out_last(n1_out_last), .out_sel(n1_out_sel),
    .out_ready(n1_out_ready)
  );

  typedef struct {
    logic [9:0] valid;
    logic [9:0] exp_rdy;
    logic       exp_vld;
    int         exp_sel;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] pat(input int i);
    return 16'hC000 | 16'(i * 257);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{10'b0000001100, 10'b0000000100, 1'b1, 2};
    vecs[1] = '{10'b1000000000, 10'b1000000000, 1'b1, 9};
    vecs[2] = '{10'b0000000001, 10'b0000000001, 1'b1, 0};
    vecs[3] = '{10'b1111111111, 10'b0000000001, 1'b1, 0};
    vecs[4] = '{10'b0101010000, 10'b0000010000, 1'b1, 4};
    vecs[5] = '{10'b0000000000, 10'b0000000000, 1'b0, 4};

    for (int i = 0; i < 10; i++) in_data[i*16 +: 16] = pat(i);
    in_valid = '1;
    in_last = '1;
    out_ready = 1'b1;
    n1_in_data = 8'h00;
    n1_in_valid = 1'b0;
    n1_in_last = 1'b0;
    n1_out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state, with requests already pending.
    #12;
    chk("rst fp in_ready", 32'(fp_in_ready), 32'h0);
    chk("rst rr in_ready", 32'(rr_in_ready), 32'h0);
    chk("rst out_valid", 32'(fp_out_valid), 32'h0);
    chk("rst out_data", 32'(fp_out_data), 32'h0);
    chk("rst out_sel", 32'(fp_out_sel), 32'h0);
    chk("rst out_last", 32'(fp_out_last), 32'h0);
    in_valid = '0;
    rst_n = 1'b1;
    tick();

    // Fixed priority table.
    for (int v = 0; v < 6; v++) begin
      in_valid = vecs[v].valid;
      @(negedge clk);
      chk($sformatf("fp v%0d in_ready", v), 32'(fp_in_ready), 32'(vecs[v].exp_rdy));
      tick();
      chk($sformatf("fp v%0d out_valid", v), 32'(fp_out_valid), 32'(vecs[v].exp_vld));
      chk($sformatf("fp v%0d out_sel", v), 32'(fp_out_sel), 32'(vecs[v].exp_sel));
      chk($sformatf("fp v%0d out_data", v), 32'(fp_out_data), 32'(pat(vecs[v].exp_sel)));
      chk($sformatf("fp v%0d out_last", v), 32'(fp_out_last), 32'h1);
    end

    // Round robin: all channels valid, 0..9,0 with no bubbles.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    in_valid = '1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk($sformatf("rr seq%0d sel", k), 32'(rr_out_sel), 32'(k % 10));
      chk($sformatf("rr seq%0d valid", k), 32'(rr_out_valid), 32'h1);
      chk($sformatf("rr seq%0d data", k), 32'(rr_out_data), 32'(pat(k % 10)));
    end
    chk("rr out_last", 32'(rr_out_last), 32'h1);

    // Backpressure for 3 cycles, then the next beat loads on the release edge.
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp in_ready", 32'(rr_in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d sel", k), 32'(rr_out_sel), 32'h0);
      chk($sformatf("bp%0d data", k), 32'(rr_out_data), 32'(pat(0)));
      chk($sformatf("bp%0d valid", k), 32'(rr_out_valid), 32'h1);
      chk($sformatf("bp%0d fp in_ready", k), 32'(fp_in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 32'(rr_in_ready), 32'h2);
    tick();
    chk("bp release sel", 32'(rr_out_sel), 32'h1);
    repeat (3) tick();
    chk("pre-reset sel", 32'(rr_out_sel), 32'h4);

    // Async reset mid-stream with ptr=5.
    rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(rr_out_valid), 32'h0);
    chk("async rst data", 32'(rr_out_data), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post-rst rr sel", 32'(rr_out_sel), 32'h0);
    chk("post-rst rr valid", 32'(rr_out_valid), 32'h1);
    chk("post-rst fp sel", 32'(fp_out_sel), 32'h0);

`ifdef MUX_ARB_LOCK_EN
    // ch3 packet of 3 beats holds the grant against ch0, even across a valid gap.
    rst_n = 1'b0;
    in_valid = 10'b0000001000;
    in_last = '0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("lk b1 in_ready", 32'(fp_in_ready), 32'h8);
    tick();
    chk("lk b1 sel", 32'(fp_out_sel), 32'h3);
    in_valid = 10'b0000001001;
    @(negedge clk);
    chk("lk b2 in_ready", 32'(fp_in_ready), 32'h8);
    tick();
    chk("lk b2 sel", 32'(fp_out_sel), 32'h3);
    in_valid = 10'b0000000001;
    @(negedge clk);
    chk("lk gap in_ready", 32'(fp_in_ready), 32'h0);
    tick();
    chk("lk gap valid", 32'(fp_out_valid), 32'h0);
    in_valid = 10'b0000001001;
    in_last = 10'b0000001000;
    @(negedge clk);
    chk("lk b3 in_ready", 32'(fp_in_ready), 32'h8);
    tick();
    chk("lk b3 sel", 32'(fp_out_sel), 32'h3);
    chk("lk b3 last", 32'(fp_out_last), 32'h1);
    in_valid = 10'b0000000001;
    @(negedge clk);
    chk("lk ch0 in_ready", 32'(fp_in_ready), 32'h1);
    tick();
    chk("lk ch0 sel", 32'(fp_out_sel), 32'h0);
`endif

    // Single-channel build.
    n1_in_valid = 1'b1;
    n1_in_data = 8'hA5;
    n1_in_last = 1'b0;
    @(negedge clk);
    chk("n1 in_ready", 32'(n1_in_ready), 32'h1);
    tick();
    chk("n1 data A5", 32'(n1_out_data), 32'hA5);
    chk("n1 valid", 32'(n1_out_valid), 32'h1);
    chk("n1 sel", 32'(n1_out_sel), 32'h0);
    chk("n1 last0", 32'(n1_out_last), 32'h0);
    n1_in_data = 8'h3C;
    n1_in_last = 1'b1;
    tick();
    chk("n1 data 3C", 32'(n1_out_data), 32'h3C);
    chk("n1 last1", 32'(n1_out_last), 32'h1);
    n1_in_valid = 1'b0;
    tick();
    chk("n1 drain valid", 32'(n1_out_valid), 32'h0);
    chk("n1 drain data", 32'(n1_out_data), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
